// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared types and helpers for the snake step scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

  // Direction encoding; opposite directions differ only in bit 0.
  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    MOVE  = 3'd2,
    EVAL  = 3'd3,
    OVER  = 3'd4
  } sched_state_t;

  // Direction that would make the snake turn back onto itself.
  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      default: r = LEFT;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_latch.sv
`default_nettype none
// ============================================================================
// Module      : snake_dir_latch
// Description : Priority-encodes the direction buttons (up > down > left >
//               right), rejects reversals of the current direction and holds
//               the most recent accepted request as dir_next.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_latch
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  dir_t       dir_cur,
  output dir_t       dir_next
);

  dir_t dir_next_q;
  dir_t dir_next_d;
  dir_t req;
  logic req_valid;

  // Pick the highest-priority pressed button and accept it unless it reverses.
  always_comb begin
    req        = dir_next_q;
    req_valid  = 1'b1;
    dir_next_d = dir_next_q;
    if (btn[0])      req = UP;
    else if (btn[1]) req = DOWN;
    else if (btn[2]) req = LEFT;
    else if (btn[3]) req = RIGHT;
    else             req_valid = 1'b0;
    if (req_valid && (req != opposite(dir_cur))) begin
      dir_next_d = req;
    end
  end

  // Pending-direction register; a fresh game starts heading right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_next_q <= RIGHT;
    end else begin
      dir_next_q <= dir_next_d;
    end
  end

  assign dir_next = dir_next_q;

endmodule
`default_nettype wire

// File: rtl/snake_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snake_step_scheduler
// Description : Times snake steps with a difficulty-dependent period, runs the
//               move request/acknowledge handshake with the datapath, issues
//               grow pulses, speeds the game up on food and raises game_over
//               on a wall hit.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter int CNT_W        = 25,
  parameter int TICKS_NORMAL = 25_000_000,
  parameter int TICKS_HARD   = 12_500_000,
  parameter int SPEEDUP      = 1_000_000,
  parameter int MIN_TICKS    = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        difficulty,
  input  logic [3:0]  btn,
  output logic        move_req,
  output logic [1:0]  dir,
  input  logic        move_ack,
  input  logic        food_hit,
  input  logic        wall_hit,
  output logic        grow,
  output logic        game_over,
  output logic [15:0] step_count
);

  localparam logic [CNT_W-1:0] PERIOD_NORMAL = CNT_W'(TICKS_NORMAL);
  localparam logic [CNT_W-1:0] PERIOD_HARD   = CNT_W'(TICKS_HARD);
  localparam logic [CNT_W-1:0] PERIOD_MIN    = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W:0]   SPEEDUP_EXT   = (CNT_W+1)'(SPEEDUP);
  localparam logic [CNT_W:0]   MIN_EXT       = (CNT_W+1)'(MIN_TICKS);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [15:0]      step_count_q, step_count_d;
  dir_t             dir_cur_q, dir_cur_d;
  dir_t             dir_next;
  logic             food_q, food_d;
  logic             wall_q, wall_d;

  // One extra bit catches underflow so a large SPEEDUP still clamps to the floor.
  logic [CNT_W:0]   period_sub;
  logic             period_floor;

  assign period_sub   = {1'b0, period_q} - SPEEDUP_EXT;
  assign period_floor = period_sub[CNT_W] || (period_sub < MIN_EXT);

  snake_dir_latch u_dir_latch (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .dir_cur  (dir_cur_q),
    .dir_next (dir_next)
  );

  // Next-state logic: step timing, handshake, evaluation and abort on run low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    period_d     = period_q;
    step_count_d = step_count_q;
    dir_cur_d    = dir_cur_q;
    food_d       = food_q;
    wall_d       = wall_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          period_d     = difficulty ? PERIOD_HARD : PERIOD_NORMAL;
          step_count_d = '0;
          dir_cur_d    = RIGHT;
          state_d      = COUNT;
        end
      end

      COUNT: begin
        if (cnt_q == (period_q - CNT_W'(1))) begin
          dir_cur_d = dir_next;
          state_d   = MOVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      MOVE: begin
        if (move_ack) begin
          food_d  = food_hit;
          wall_d  = wall_hit;
          state_d = EVAL;
        end
      end

      EVAL: begin
        if (step_count_q != 16'hFFFF) begin
          step_count_d = step_count_q + 16'd1;
        end
        if (wall_q) begin
          state_d = OVER;
        end else begin
          if (food_q) begin
            period_d = period_floor ? PERIOD_MIN : period_sub[CNT_W-1:0];
          end
          state_d = COUNT;
        end
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving the play stage overrides everything: no step, no grow, no speedup.
    if (!run && (state_q != IDLE)) begin
      state_d      = IDLE;
      cnt_d        = '0;
      period_d     = period_q;
      step_count_d = step_count_q;
      dir_cur_d    = dir_cur_q;
      food_d       = food_q;
      wall_d       = wall_q;
    end
  end

  // State, counter, period and step bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= PERIOD_NORMAL;
      step_count_q <= '0;
      dir_cur_q    <= RIGHT;
      food_q       <= 1'b0;
      wall_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      step_count_q <= step_count_d;
      dir_cur_q    <= dir_cur_d;
      food_q       <= food_d;
      wall_q       <= wall_d;
    end
  end

  // Outputs are decoded from registers only; food/wall were captured on ack.
  assign move_req   = (state_q == MOVE);
  assign game_over  = (state_q == OVER);
  assign grow       = (state_q == EVAL) && food_q && !wall_q;
  assign dir        = dir_cur_q;
  assign step_count = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_step_scheduler
// Description : Randomised self-checking bench with a behavioural game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_step_scheduler;

  localparam int TN = 8;
  localparam int TH = 4;
  localparam int SU = 2;
  localparam int MT = 2;

  localparam int S_IDLE  = 0;
  localparam int S_COUNT = 1;
  localparam int S_MOVE  = 2;
  localparam int S_EVAL  = 3;
  localparam int S_OVER  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        difficulty = 1'b0;
  logic [3:0]  btn = 4'b0000;
  logic        move_ack = 1'b0;
  logic        food_hit = 1'b0;
  logic        wall_hit = 1'b0;
  logic        move_req;
  logic [1:0]  dir;
  logic        grow;
  logic        game_over;
  logic [15:0] step_count;

  snake_step_scheduler #(
    .CNT_W        (25),
    .TICKS_NORMAL (TN),
    .TICKS_HARD   (TH),
    .SPEEDUP      (SU),
    .MIN_TICKS    (MT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .difficulty (difficulty),
    .btn        (btn),
    .move_req   (move_req),
    .dir        (dir),
    .move_ack   (move_ack),
    .food_hit   (food_hit),
    .wall_hit   (wall_hit),
    .grow       (grow),
    .game_over  (game_over),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: game phase, cycles left before the move, current period.
  int m_st, m_left, m_period, m_steps, m_dcur, m_dnext;
  bit m_food, m_wall;

  int ack_mode;   // 0 prompt, 1 never, 2 random delay
  int food_mode;  // 0 random, 1 always, 2 never
  int wall_mode;  // 0 never, 1 always, 2 rare

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_left = 0; m_period = TN; m_steps = 0;
    m_dcur = 3; m_dnext = 3; m_food = 0; m_wall = 0;
  endtask

  task automatic model_clock();
    int req, nd;
    req = -1;
    if (btn[0])      req = 0;
    else if (btn[1]) req = 1;
    else if (btn[2]) req = 2;
    else if (btn[3]) req = 3;
    nd = m_dnext;
    if (req >= 0 && req != (m_dcur ^ 1)) nd = req;
    if (!run) begin
      m_st = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE: begin
          m_period = difficulty ? TH : TN;
          m_steps = 0; m_dcur = 3; m_st = S_COUNT; m_left = m_period;
        end
        S_COUNT: begin
          m_left--;
          if (m_left == 0) begin m_dcur = m_dnext; m_st = S_MOVE; end
        end
        S_MOVE: begin
          if (move_ack) begin m_food = food_hit; m_wall = wall_hit; m_st = S_EVAL; end
        end
        S_EVAL: begin
          if (m_steps < 65535) m_steps++;
          if (m_wall) m_st = S_OVER;
          else begin
            if (m_food) m_period = (m_period - SU < MT) ? MT : m_period - SU;
            m_st = S_COUNT; m_left = m_period;
          end
        end
        default: ;
      endcase
    end
    m_dnext = nd;
  endtask

  task automatic check_outputs();
    check_val("move_req", 32'(move_req), 32'(m_st == S_MOVE));
    check_val("grow", 32'(grow), 32'(m_st == S_EVAL && m_food && !m_wall));
    check_val("game_over", 32'(game_over), 32'(m_st == S_OVER));
    check_val("dir", 32'(dir), 32'(m_dcur));
    check_val("step_count", 32'(step_count), 32'(m_steps));
  endtask

  // One clock: advance the model, compare, then drive the handshake inputs.
  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
    move_ack = 1'b0;
    if (m_st == S_MOVE) begin
      case (ack_mode)
        0:       move_ack = 1'b1;
        1:       move_ack = 1'b0;
        default: move_ack = ($urandom_range(0, 2) == 0);
      endcase
    end
    food_hit = 1'($urandom_range(0, 1));
    wall_hit = 1'($urandom_range(0, 1));
    if (move_ack) begin
      food_hit = (food_mode == 1) ? 1'b1 : (food_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      wall_hit = (wall_mode == 1) ? 1'b1 : (wall_mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
  endtask

  task automatic wait_move(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (move_req !== 1'b1 && n < 100);
  endtask

  task automatic wait_grow(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (grow !== 1'b1 && n < 100);
  endtask

  initial begin
    int n;
    ack_mode = 0; food_mode = 2; wall_mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // First move timing, normal difficulty
    difficulty = 1'b0; run = 1'b1;
    wait_move(n);
    check_val("first_move_latency", 32'(n), 32'd9);
    check_val("first_dir", 32'(dir), 32'd3);
    cycle();
    cycle();
    check_val("steps_after_eval", 32'(step_count), 32'd1);

    // Reversal rejection, then priority up over left
    btn = 4'b0100;
    cycle();
    btn = 4'b0000;
    wait_move(n);
    check_val("reversal_ignored", 32'(dir), 32'd3);
    btn = 4'b0101;
    cycle();
    btn = 4'b0000;
    wait_move(n);
    check_val("priority_up", 32'(dir), 32'd0);
    run = 1'b0;
    cycle();

    // Hard difficulty with speedup down to the floor
    difficulty = 1'b1; food_mode = 1; run = 1'b1;
    wait_move(n);
    check_val("hard_count_len", 32'(n), 32'(TH + 1));
    for (int k = 0; k < 3; k++) begin
      wait_grow(n);
      check_val("grow_seen", 32'(grow), 32'd1);
      wait_move(n);
      check_val("sped_count_len", 32'(n), 32'(MT + 1));
    end
    run = 1'b0;
    cycle();

    // Simultaneous food and wall
    difficulty = 1'b0; food_mode = 1; wall_mode = 1; run = 1'b1;
    wait_move(n);
    cycle();
    check_val("wall_wins_no_grow", 32'(grow), 32'd0);
    cycle();
    check_val("game_over_set", 32'(game_over), 32'd1);
    repeat (5) cycle();
    run = 1'b0;
    cycle();
    check_val("game_over_clear", 32'(game_over), 32'd0);

    // Stalled datapath, then abort
    wall_mode = 0; food_mode = 1; ack_mode = 1; run = 1'b1;
    wait_move(n);
    repeat (20) cycle();
    check_val("stall_req_held", 32'(move_req), 32'd1);
    run = 1'b0;
    cycle();
    check_val("abort_req_low", 32'(move_req), 32'd0);
    check_val("abort_no_grow", 32'(grow), 32'd0);

    // Reset mid-MOVE after a few completed moves
    ack_mode = 0; food_mode = 0; run = 1'b1;
    btn = 4'b0001;
    for (int k = 0; k < 3; k++) wait_move(n);
    btn = 4'b0000;
    ack_mode = 1;
    wait_move(n);
    wait_move(n);
    check_val("pre_reset_move", 32'(move_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #2 rst = 1'b0;

    // Randomised play
    ack_mode = 2; food_mode = 0; wall_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      btn = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      difficulty = 1'($urandom_range(0, 1));
      if (run) run = ($urandom_range(0, 199) != 0);
      else     run = ($urandom_range(0, 3) == 0);
      if (m_st == S_OVER && $urandom_range(0, 9) == 0) run = 1'b0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
